// File: rtl/pwm_dead_time_generator.sv
// pwm_dead_time_generator
//
// Complementary PWM stage that sits beside a timer_counter. The active top and
// compare values are driven to the timer, and its overflow and compare_match
// pulses are consumed. A raw PWM level is derived from those pulses. The raw
// level is then split into a high-side/low-side gate pair, with a programmable
// dead time inserted on every raw edge. New configurations are accepted over a
// valid/ready handshake into a shadow slot. They move to the active registers
// only at a period boundary (overflow) or immediately while the block is
// disabled.
//
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   enable                 run; the same signal feeds the timer's enable
//   config_valid/ready     handshake for the shadow slot (ready = slot free)
//   config_top             period top value
//   config_compare         duty compare value
//   config_dead_time       dead time in clock cycles
//   top_value              active top, to timer
//   compare_value          active compare, to timer
//   overflow               from timer, one-cycle pulse at the start of a period
//   compare_match          from timer, counter == compare_value
//   pwm_high, pwm_low      complementary gate outputs, never both high
//   update_applied         one-cycle pulse when the shadow has moved to active
//
// Optional build macro PWM_DEAD_TIME_FAULT_EN adds:
//   fault                  asynchronous fault input, double-registered here
//   fault_clear            clears the latched fault once the fault is gone
//   fault_latched          sticky fault indication
//
// Output FSM:
//   state           | meaning
//   IDLE            | disabled or faulted, both gates off
//   LOW_ON          | raw low and dead time elapsed, low-side gate on
//   DEAD_TO_HIGH    | raw went high, waiting out dead time, both gates off
//   HIGH_ON         | raw high and dead time elapsed, high-side gate on
//   DEAD_TO_LOW     | raw went low (or run started), waiting, both gates off

module pwm_dead_time_generator #(
    parameter  int MAX_COUNTER_VALUE = 255,
    parameter  int DEAD_TIME_BITS    = 8,
    localparam int COUNTER_BITS      = $clog2(MAX_COUNTER_VALUE + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      config_valid,
    output logic                      config_ready,
    input  logic [COUNTER_BITS-1:0]   config_top,
    input  logic [COUNTER_BITS-1:0]   config_compare,
    input  logic [DEAD_TIME_BITS-1:0] config_dead_time,
    output logic [COUNTER_BITS-1:0]   top_value,
    output logic [COUNTER_BITS-1:0]   compare_value,
    input  logic                      overflow,
    input  logic                      compare_match,
    output logic                      pwm_high,
    output logic                      pwm_low,
`ifdef PWM_DEAD_TIME_FAULT_EN
    input  logic                      fault,
    input  logic                      fault_clear,
    output logic                      fault_latched,
`endif
    output logic                      update_applied
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW_ON,
        ST_DEAD_TO_HIGH,
        ST_HIGH_ON,
        ST_DEAD_TO_LOW
    } state_t;

    logic [COUNTER_BITS-1:0]   top_q, top_d;
    logic [COUNTER_BITS-1:0]   compare_q, compare_d;
    logic [DEAD_TIME_BITS-1:0] dead_q, dead_d;
    logic [COUNTER_BITS-1:0]   sh_top_q, sh_top_d;
    logic [COUNTER_BITS-1:0]   sh_compare_q, sh_compare_d;
    logic [DEAD_TIME_BITS-1:0] sh_dead_q, sh_dead_d;
    logic                      pending_q, pending_d;
    logic                      update_applied_q, update_applied_d;
    logic                      raw_q, raw_d;

    state_t                    state_q, state_d;
    logic [DEAD_TIME_BITS-1:0] dcnt_q, dcnt_d;

    logic                      transfer;
    logic                      apply;
    logic                      blocked;
    logic                      run;

`ifdef PWM_DEAD_TIME_FAULT_EN
    logic fault_meta_q, fault_meta_d;
    logic fault_sync_q, fault_sync_d;
    logic fault_latched_q, fault_latched_d;

    always_comb begin
        fault_meta_d    = fault;
        fault_sync_d    = fault_meta_q;
        fault_latched_d = fault_latched_q;
        if (fault_sync_q) begin
            fault_latched_d = 1'b1;
        end else if (fault_clear) begin
            fault_latched_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fault_meta_q    <= 1'b0;
            fault_sync_q    <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            fault_meta_q    <= fault_meta_d;
            fault_sync_q    <= fault_sync_d;
            fault_latched_q <= fault_latched_d;
        end
    end

    // Outputs stay parked while the fault is present or still latched.
    assign blocked       = fault_sync_q || fault_latched_q;
    assign fault_latched = fault_latched_q;
`else
    assign blocked = 1'b0;
`endif

    assign run = enable && !blocked;

    // Shadow handshake, shadow-to-active transfer and raw PWM level.
    always_comb begin
        top_d            = top_q;
        compare_d        = compare_q;
        dead_d           = dead_q;
        sh_top_d         = sh_top_q;
        sh_compare_d     = sh_compare_q;
        sh_dead_d        = sh_dead_q;
        pending_d        = pending_q;
        update_applied_d = 1'b0;

        // A transfer needs an empty slot and an apply needs a full one, so
        // the two never happen in the same cycle. A config that arrives in an
        // overflow cycle therefore waits for the next overflow.
        transfer = config_valid && !pending_q;
        apply    = pending_q && (overflow || !enable);

        if (transfer) begin
            sh_top_d     = config_top;
            sh_compare_d = config_compare;
            sh_dead_d    = config_dead_time;
            pending_d    = 1'b1;
        end

        if (apply) begin
            top_d            = sh_top_q;
            compare_d        = sh_compare_q;
            dead_d           = sh_dead_q;
            pending_d        = 1'b0;
            update_applied_d = 1'b1;
        end

        // Clear beats set, so compare == 0 gives 0 % duty even on overflow.
        if (!run) begin
            raw_d = 1'b0;
        end else if (compare_match || (compare_q == '0)) begin
            raw_d = 1'b0;
        end else if (overflow) begin
            raw_d = 1'b1;
        end else begin
            raw_d = raw_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            top_q            <= COUNTER_BITS'(MAX_COUNTER_VALUE);
            compare_q        <= '0;
            dead_q           <= '0;
            sh_top_q         <= '0;
            sh_compare_q     <= '0;
            sh_dead_q        <= '0;
            pending_q        <= 1'b0;
            update_applied_q <= 1'b0;
            raw_q            <= 1'b0;
        end else begin
            top_q            <= top_d;
            compare_q        <= compare_d;
            dead_q           <= dead_d;
            sh_top_q         <= sh_top_d;
            sh_compare_q     <= sh_compare_d;
            sh_dead_q        <= sh_dead_d;
            pending_q        <= pending_d;
            update_applied_q <= update_applied_d;
            raw_q            <= raw_d;
        end
    end

    // FSM: state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // FSM: next state. Any raw change (or leaving IDLE) restarts the dead
    // interval toward the new raw level. The counter holds dead cycles still
    // to wait, so a zero dead time goes straight to the ON state.
    always_comb begin
        logic load;

        state_d = state_q;
        dcnt_d  = dcnt_q;
        load    = 1'b0;

        if (!run) begin
            state_d = ST_IDLE;
            dcnt_d  = '0;
        end else if ((state_q == ST_IDLE) || (raw_d != raw_q)) begin
            load = 1'b1;
        end else begin
            case (state_q)
                ST_DEAD_TO_HIGH: begin
                    if (dcnt_q <= DEAD_TIME_BITS'(1)) begin
                        state_d = ST_HIGH_ON;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q - DEAD_TIME_BITS'(1);
                    end
                end
                ST_DEAD_TO_LOW: begin
                    if (dcnt_q <= DEAD_TIME_BITS'(1)) begin
                        state_d = ST_LOW_ON;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q - DEAD_TIME_BITS'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        if (load) begin
            dcnt_d = dead_q;
            if (dead_q == '0) begin
                state_d = raw_d ? ST_HIGH_ON : ST_LOW_ON;
            end else begin
                state_d = raw_d ? ST_DEAD_TO_HIGH : ST_DEAD_TO_LOW;
            end
        end
    end

    // FSM: outputs. Each gate is decoded from a single distinct state, so
    // the two gates can never be high together.
    always_comb begin
        pwm_high = 1'b0;
        pwm_low  = 1'b0;
        case (state_q)
            ST_HIGH_ON: pwm_high = 1'b1;
            ST_LOW_ON:  pwm_low  = 1'b1;
            default: begin
                pwm_high = 1'b0;
                pwm_low  = 1'b0;
            end
        endcase
    end

    assign config_ready   = !pending_q;
    assign top_value      = top_q;
    assign compare_value  = compare_q;
    assign update_applied = update_applied_q;

endmodule

// File: tb/tb_pwm_dead_time_generator.sv
module tb_pwm_dead_time_generator;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       config_valid;
    logic [7:0] config_top;
    logic [7:0] config_compare;
    logic [7:0] config_dead_time;
    logic [7:0] top_value;
    logic [7:0] compare_value;
    logic       config_ready;
    logic       pwm_high;
    logic       pwm_low;
    logic       update_applied;
    logic       overflow;
    logic       compare_match;
    logic [7:0] tcnt;
`ifdef PWM_DEAD_TIME_FAULT_EN
    logic       fault;
    logic       fault_clear;
    logic       fault_latched;
`endif

    always #5 clock = ~clock;

    pwm_dead_time_generator #(
        .MAX_COUNTER_VALUE(255),
        .DEAD_TIME_BITS   (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .config_valid    (config_valid),
        .config_ready    (config_ready),
        .config_top      (config_top),
        .config_compare  (config_compare),
        .config_dead_time(config_dead_time),
        .top_value       (top_value),
        .compare_value   (compare_value),
        .overflow        (overflow),
        .compare_match   (compare_match),
        .pwm_high        (pwm_high),
        .pwm_low         (pwm_low),
`ifdef PWM_DEAD_TIME_FAULT_EN
        .fault           (fault),
        .fault_clear     (fault_clear),
        .fault_latched   (fault_latched),
`endif
        .update_applied  (update_applied)
    );

    // Stand-in for the timer_counter: counts 0..top, wraps, held at 0 when off.
    always @(posedge clock) begin
        if (reset || !enable)       tcnt <= 8'd0;
        else if (tcnt >= top_value) tcnt <= 8'd0;
        else                        tcnt <= tcnt + 8'd1;
    end
    assign overflow      = enable && (tcnt == 8'd0);
    assign compare_match = enable && (tcnt == compare_value);

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [7:0] m_top, m_cmp, m_dead, s_top, s_cmp, s_dead;
    logic       m_pend, m_upd, m_raw, m_run;
    int         m_stable;   // cycles the raw level has held inside the run
    int         m_load;     // dead time in force for the current raw level
    logic       m_f1, m_f2, m_latch;

    // Inputs sampled just before each active edge.
    logic       p_rst, p_en, p_v, p_ov, p_cm, p_fault, p_fc;
    logic [7:0] p_top, p_cmp, p_dead;

    logic       last_xfer;
    int         hi_cnt, lo_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic b, run_n, raw_n, xfer, apply;
        last_xfer = 1'b0;
        if (p_rst) begin
            m_top = 8'd255; m_cmp = 8'd0; m_dead = 8'd0;
            m_pend = 1'b0; m_upd = 1'b0; m_raw = 1'b0; m_run = 1'b0;
            m_stable = 0; m_load = 0;
            m_f1 = 1'b0; m_f2 = 1'b0; m_latch = 1'b0;
        end else begin
            b = m_f2 || m_latch;
            run_n = p_en && !b;
            if (!run_n)                     raw_n = 1'b0;
            else if (p_cm || m_cmp == 8'd0) raw_n = 1'b0;
            else if (p_ov)                  raw_n = 1'b1;
            else                            raw_n = m_raw;
            if (run_n) begin
                if (!m_run || raw_n != m_raw) begin
                    m_load   = int'(m_dead);
                    m_stable = 1;
                end else begin
                    m_stable++;
                end
            end else begin
                m_stable = 0;
            end
            m_run = run_n;
            m_raw = raw_n;

            xfer  = p_v && !m_pend;
            apply = m_pend && (p_ov || !p_en);
            m_upd = apply;
            if (apply) begin
                m_top = s_top; m_cmp = s_cmp; m_dead = s_dead; m_pend = 1'b0;
            end
            if (xfer) begin
                s_top = p_top; s_cmp = p_cmp; s_dead = p_dead; m_pend = 1'b1;
            end
            last_xfer = xfer;

            if (m_f2)      m_latch = 1'b1;
            else if (p_fc) m_latch = 1'b0;
            m_f2 = m_f1;
            m_f1 = p_fault;
        end
    endtask

    task automatic step();
        logic exp_hi, exp_lo;
        @(negedge clock);
        p_rst = reset; p_en = enable; p_v = config_valid;
        p_top = config_top; p_cmp = config_compare; p_dead = config_dead_time;
        p_ov = overflow; p_cm = compare_match;
        p_fault = 1'b0; p_fc = 1'b0;
`ifdef PWM_DEAD_TIME_FAULT_EN
        p_fault = fault; p_fc = fault_clear;
`endif
        @(posedge clock);
        #1;
        model_update();
        exp_hi = m_run && m_raw && (m_stable >= m_load + 1);
        exp_lo = m_run && !m_raw && (m_stable >= m_load + 1);
        chk("pwm_high", 32'(pwm_high), 32'(exp_hi));
        chk("pwm_low", 32'(pwm_low), 32'(exp_lo));
        chk("never_both", 32'(pwm_high && pwm_low), 32'd0);
        chk("config_ready", 32'(config_ready), 32'(!m_pend));
        chk("update_applied", 32'(update_applied), 32'(m_upd));
        chk("top_value", 32'(top_value), 32'(m_top));
        chk("compare_value", 32'(compare_value), 32'(m_cmp));
`ifdef PWM_DEAD_TIME_FAULT_EN
        chk("fault_latched", 32'(fault_latched), 32'(m_latch));
`endif
        if (pwm_high) hi_cnt++;
        if (pwm_low)  lo_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [7:0] t, input logic [7:0] c, input logic [7:0] d);
        int k;
        config_valid = 1'b1; config_top = t; config_compare = c; config_dead_time = d;
        k = 0;
        last_xfer = 1'b0;
        while (!last_xfer && k < 600) begin
            step();
            k++;
        end
        chk("push_accepted", 32'(last_xfer), 32'd1);
        config_valid = 1'b0;
    endtask

    task automatic wait_ov();
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!p_ov && k < 300);
        chk("overflow_seen", 32'(p_ov), 32'd1);
    endtask

    task automatic window(input int n);
        hi_cnt = 0; lo_cnt = 0;
        run(n);
    endtask

    initial begin
        logic [7:0] rt, rc, rd;
        int unsigned r;
        int k;
        reset = 1'b1; enable = 1'b0; config_valid = 1'b0;
        config_top = 8'd0; config_compare = 8'd0; config_dead_time = 8'd0;
`ifdef PWM_DEAD_TIME_FAULT_EN
        fault = 1'b0; fault_clear = 1'b0;
`endif
        run(3);
        chk("reset_top", 32'(top_value), 32'd255);
        chk("reset_compare", 32'(compare_value), 32'd0);
        chk("reset_ready", 32'(config_ready), 32'd1);
        chk("reset_outputs", 32'({pwm_high, pwm_low, update_applied}), 32'd0);
        reset = 1'b0;

        // 1: configure while disabled, then run.
        push(8'd9, 8'd3, 8'd1);
        step();
        chk("t1_update_pulse", 32'(update_applied), 32'd1);
        step();
        chk("t1_update_one_cycle", 32'(update_applied), 32'd0);
        enable = 1'b1;
        run(40);
        window(10);
        chk("t1_high_cycles", 32'(hi_cnt), 32'd2);
        chk("t1_low_cycles", 32'(lo_cnt), 32'd6);

        // 2: change compare mid-period.
        run(4);
        push(8'd9, 8'd7, 8'd1);
        chk("t2_ready_low", 32'(config_ready), 32'd0);
        run(30);
        window(10);
        chk("t2_high_cycles", 32'(hi_cnt), 32'd6);
        chk("t2_low_cycles", 32'(lo_cnt), 32'd2);

        // 3: transfer in the overflow cycle.
        k = 0;
        while (tcnt != 8'd0 && k < 50) begin step(); k++; end
        push(8'd9, 8'd3, 8'd1);
        window(10);
        chk("t3_old_high", 32'(hi_cnt), 32'd6);
        chk("t3_old_low", 32'(lo_cnt), 32'd2);
        window(10);
        chk("t3_new_high", 32'(hi_cnt), 32'd2);
        chk("t3_new_low", 32'(lo_cnt), 32'd6);

        // 4: raw pulse shorter than dead time.
        push(8'd9, 8'd3, 8'd4);
        run(30);
        window(30);
        chk("t4_high_suppressed", 32'(hi_cnt), 32'd0);
        chk("t4_low_cycles", 32'(lo_cnt), 32'd9);

        // 5: 0 % then 100 % duty.
        push(8'd9, 8'd0, 8'd1);
        run(30);
        window(20);
        chk("t5_zero_high", 32'(hi_cnt), 32'd0);
        chk("t5_zero_low", 32'(lo_cnt), 32'd20);
        push(8'd9, 8'd15, 8'd1);
        run(30);
        window(20);
        chk("t5_full_high", 32'(hi_cnt), 32'd20);
        chk("t5_full_low", 32'(lo_cnt), 32'd0);

        // Maximum dead time, no counter wrap.
        push(8'd9, 8'd0, 8'd255);
        run(40);
        window(200);
        chk("dead_max_low_wait", 32'(lo_cnt), 32'd0);
        run(80);
        chk("dead_max_low_on", 32'(pwm_low), 32'd1);

        // 6: disable mid DEAD_TO_HIGH, then reset mid HIGH_ON.
        push(8'd9, 8'd7, 8'd4);
        run(30);
        wait_ov();
        step();
        enable = 1'b0;
        step();
        chk("t6_disable_outputs", 32'({pwm_high, pwm_low}), 32'd0);
        run(12);
        enable = 1'b1;
        wait_ov();
        run(4);
        chk("t6_high_before_reset", 32'(pwm_high), 32'd1);
        config_valid = 1'b1; config_top = 8'd5; config_compare = 8'd2; config_dead_time = 8'd0;
        step();
        config_valid = 1'b0;
        chk("t6_pending", 32'(config_ready), 32'd0);
        reset = 1'b1;
        step();
        chk("t6_reset_outputs", 32'({pwm_high, pwm_low}), 32'd0);
        chk("t6_reset_ready", 32'(config_ready), 32'd1);
        reset = 1'b0;
        run(20);

`ifdef PWM_DEAD_TIME_FAULT_EN
        push(8'd9, 8'd3, 8'd1);
        run(30);
        fault = 1'b1;
        step();
        fault = 1'b0;
        run(3);
        chk("fault_outputs_off", 32'({pwm_high, pwm_low}), 32'd0);
        window(20);
        chk("fault_held_off", 32'(hi_cnt + lo_cnt), 32'd0);
        fault_clear = 1'b1;
        step();
        fault_clear = 1'b0;
        run(30);
        window(10);
        chk("fault_resumed_high", 32'(hi_cnt), 32'd2);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                rt = 8'($urandom_range(1, 20));
                rc = 8'($urandom_range(0, int'(rt) + 3));
                rd = 8'($urandom_range(0, 5));
                push(rt, rc, rd);
            end else if (r < 8) begin
                enable = ~enable;
            end else begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            run(int'($urandom_range(1, 25)));
        end
        enable = 1'b1;
        run(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
